// File: rtl/cache_controller.sv
// Load/store sequencer for cache_memory: write-through, no-write-allocate, round-robin victim on full sets.
// Optional hit/miss counters are enabled by defining CACHE_CTRL_PERF_EN.
module cache_controller #(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned NUM_SETS   = 4,
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned BLOCK_SIZE = 32,
  localparam int unsigned OffsetSize = $clog2(BLOCK_SIZE / 8),
  localparam int unsigned SetSize    = $clog2(NUM_SETS),
  localparam int unsigned WaySize    = $clog2(NUM_WAYS),
  localparam int unsigned TagSize    = ADDR_SIZE - SetSize - OffsetSize
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic [SetSize-1:0]   cm_set,
  output logic [TagSize-1:0]   cm_tag,
  output logic [WaySize-1:0]   cm_write_way,
  output logic                 cm_write_enable,
  output logic [31:0]          cm_write_data,
  input  logic [31:0]          cm_read_data,
  input  logic                 cm_hit,
  input  logic [WaySize-1:0]   cm_hit_way,
  input  logic [WaySize-1:0]   cm_populate_way,
  input  logic                 cm_populated,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_write,
  output logic [ADDR_SIZE-1:0] mem_req_addr,
  output logic [31:0]          mem_req_wdata,
  input  logic                 mem_resp_valid,
  input  logic [31:0]          mem_resp_rdata
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_READ, WAIT_READ, FILL, MEM_WRITE} state_t;

  state_t                            state, state_d;
  logic                              write_q, write_d;
  logic [ADDR_SIZE-1:0]              addr_q, addr_d;
  logic [31:0]                       wdata_q, wdata_d;
  logic [NUM_SETS-1:0][WaySize-1:0]  victim_q, victim_d;
  logic                              req_ready_d, resp_valid_d, cm_we_d;
  logic [31:0]                       resp_rdata_d, cm_data_d, mem_wdata_d;
  logic [WaySize-1:0]                cm_way_d;
  logic                              mem_valid_d, mem_write_d;
  logic [ADDR_SIZE-1:0]              mem_addr_d;

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    cm_we_d      = 1'b0;
    cm_way_d     = cm_write_way;
    cm_data_d    = cm_write_data;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (write_q) begin
          if (cm_hit) begin
            cm_we_d   = 1'b1;
            cm_way_d  = cm_hit_way;
            cm_data_d = wdata_q;
          end
          state_d = MEM_WRITE;
        end else if (cm_hit) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = cm_read_data;
          state_d      = IDLE;
        end else begin
          state_d = MEM_READ;
        end
      end
      MEM_READ: if (mem_req_ready) state_d = WAIT_READ;
      WAIT_READ: begin
        // Fill strobe is registered, so the way is chosen here and presented during FILL.
        if (mem_resp_valid) begin
          cm_we_d   = 1'b1;
          cm_data_d = mem_resp_rdata;
          if (!cm_populated) begin
            cm_way_d = cm_populate_way;
          end else begin
            cm_way_d         = victim_q[cm_set];
            victim_d[cm_set] = (victim_q[cm_set] == WaySize'(NUM_WAYS - 1)) ? '0
                                                                             : victim_q[cm_set] + 1'b1;
          end
          state_d = FILL;
        end
      end
      FILL: begin
        // cm_write_data still holds the fetched word.
        resp_valid_d = 1'b1;
        resp_rdata_d = cm_write_data;
        state_d      = IDLE;
      end
      MEM_WRITE: begin
        if (mem_req_ready) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    mem_valid_d = (state_d == MEM_READ) || (state_d == MEM_WRITE);
    mem_write_d = (state_d == MEM_WRITE);
    mem_addr_d  = mem_valid_d ? addr_d : '0;
    mem_wdata_d = mem_write_d ? wdata_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      write_q         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      victim_q        <= '0;
      req_ready       <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      cm_set          <= '0;
      cm_tag          <= '0;
      cm_write_way    <= '0;
      cm_write_enable <= 1'b0;
      cm_write_data   <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_write   <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
    end else begin
      state           <= state_d;
      write_q         <= write_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      victim_q        <= victim_d;
      req_ready       <= req_ready_d;
      resp_valid      <= resp_valid_d;
      resp_rdata      <= resp_rdata_d;
      cm_set          <= addr_d[OffsetSize +: SetSize];
      cm_tag          <= addr_d[ADDR_SIZE-1 -: TagSize];
      cm_write_way    <= cm_way_d;
      cm_write_enable <= cm_we_d;
      cm_write_data   <= cm_data_d;
      mem_req_valid   <= mem_valid_d;
      mem_req_write   <= mem_write_d;
      mem_req_addr    <= mem_addr_d;
      mem_req_wdata   <= mem_wdata_d;
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  // Saturating lookup outcome counters, loads and stores alike.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (cm_hit && (hit_count != '1))    hit_count  <= hit_count + 32'd1;
      if (!cm_hit && (miss_count != '1))  miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller with behavioural cache_memory and main-memory models.
module tb_cache_controller;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  cm_set;
  logic [27:0] cm_tag;
  logic        cm_write_way, cm_write_enable;
  logic [31:0] cm_write_data, cm_read_data;
  logic        cm_hit, cm_hit_way, cm_populate_way, cm_populated;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .cm_set(cm_set), .cm_tag(cm_tag), .cm_write_way(cm_write_way),
    .cm_write_enable(cm_write_enable), .cm_write_data(cm_write_data),
    .cm_read_data(cm_read_data), .cm_hit(cm_hit), .cm_hit_way(cm_hit_way),
    .cm_populate_way(cm_populate_way), .cm_populated(cm_populated),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_CTRL_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int accept_dly = 2;
  int resp_dly = 2;
  int exp_hits = 0;
  int exp_misses = 0;
  int n_cwr, n_mrd, n_mwr, n_resp;
  int cwr_cyc, resp_cyc, c0;
  logic        cwr_way;
  logic [31:0] cwr_data, maddr, mdata;
  logic [31:0] sb[$];
  logic [31:0] mem_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  logic        cvld [4][2] = '{default: 1'b0};
  logic [27:0] ctag [4][2] = '{default: 28'd0};
  logic [31:0] cdat [4][2] = '{default: 32'd0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_mem.exists(a) ? mem_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Cache storage: combinational lookup, registered write.
  always_comb begin
    cm_hit = 1'b0; cm_hit_way = 1'b0; cm_read_data = 32'd0;
    cm_populated = 1'b1; cm_populate_way = 1'b0;
    for (int w = 1; w >= 0; w--) begin
      if (!cvld[cm_set][w]) begin
        cm_populated = 1'b0;
        cm_populate_way = 1'(w);
      end
      if (cvld[cm_set][w] && ctag[cm_set][w] == cm_tag) begin
        cm_hit = 1'b1;
        cm_hit_way = 1'(w);
        cm_read_data = cdat[cm_set][w];
      end
    end
  end

  always @(posedge clk) begin
    if (cm_write_enable) begin
      cvld[cm_set][cm_write_way] <= 1'b1;
      ctag[cm_set][cm_write_way] <= cm_tag;
      cdat[cm_set][cm_write_way] <= cm_write_data;
    end
  end

  // Main memory: accepts after accept_dly cycles, returns read data resp_dly+1 cycles later.
  initial begin
    int age;
    int rcnt;
    logic [31:0] rdat;
    age = 0; rcnt = -1; rdat = 32'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (rcnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdat;
        rcnt = -1;
      end else if (rcnt > 0) begin
        rcnt--;
      end
      if (mem_req_valid) begin
        if (age >= accept_dly) begin
          mem_req_ready = 1'b1;
          age = 0;
          if (mem_req_write) mem_mem[mem_req_addr] = mem_req_wdata;
          else begin
            rdat = mem_rd(mem_req_addr);
            rcnt = resp_dly;
          end
        end else age++;
      end else age = 0;
    end
  end

  // Monitor: record cache/memory activity and score responses.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      if (cm_write_enable) begin
        n_cwr++; cwr_way = cm_write_way; cwr_data = cm_write_data; cwr_cyc = cyc;
      end
      if (mem_req_valid && mem_req_ready) begin
        maddr = mem_req_addr;
        if (mem_req_write) begin
          n_mwr++; mdata = mem_req_wdata;
        end else n_mrd++;
      end
      if (resp_valid) begin
        n_resp++;
        resp_cyc = cyc;
        check("resp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) check("resp_rdata", 64'(resp_rdata), 64'(sb.pop_front()));
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    n_cwr = 0; n_mrd = 0; n_mwr = 0; n_resp = 0;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_hit, input logic exp_way);
    logic [31:0] exp;
    int k;
    exp = wr ? 32'd0 : ref_rd(addr);
    if (wr) ref_mem[addr] = wdata;
    if (exp_hit) exp_hits++; else exp_misses++;
    sb.push_back(exp);
    issue(wr, addr, wdata);
    k = 0;
    while (n_resp == 0 && k < 200) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("resp_seen", 64'(n_resp), 64'd1);
    if (!wr) begin
      check("mem_reads", 64'(n_mrd), exp_hit ? 64'd0 : 64'd1);
      check("cache_writes", 64'(n_cwr), exp_hit ? 64'd0 : 64'd1);
      if (exp_hit) check("hit_latency", 64'(resp_cyc - c0), 64'd2);
      else begin
        check("mem_rd_addr", 64'(maddr), 64'(addr));
        check("fill_way", 64'(cwr_way), 64'(exp_way));
        check("fill_data", 64'(cwr_data), 64'(exp));
        check("fill_to_resp", 64'(resp_cyc - cwr_cyc), 64'd1);
      end
    end else begin
      check("mem_writes", 64'(n_mwr), 64'd1);
      check("mem_reads", 64'(n_mrd), 64'd0);
      check("mem_wr_addr", 64'(maddr), 64'(addr));
      check("mem_wr_data", 64'(mdata), 64'(wdata));
      check("cache_writes", 64'(n_cwr), exp_hit ? 64'd1 : 64'd0);
      if (exp_hit) begin
        check("wr_hit_way", 64'(cwr_way), 64'(exp_way));
        check("wr_hit_data", 64'(cwr_data), 64'(wdata));
      end
    end
  endtask

  initial begin
    int k;
    mem_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    n_cwr = 0; n_mrd = 0; n_mwr = 0; n_resp = 0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Miss, hit, write hit, hit with the stored value.
    do_req(1'b0, 32'h100, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, 32'h100, 32'd0, 1'b1, 1'b0);
    do_req(1'b1, 32'h100, 32'h1234_5678, 1'b1, 1'b0);
    do_req(1'b0, 32'h100, 32'd0, 1'b1, 1'b0);

    // Set 0 replacement: invalid way first, then round-robin victim.
    accept_dly = 0;
    do_req(1'b0, 32'h200, 32'd0, 1'b0, 1'b1);
    do_req(1'b0, 32'h300, 32'd0, 1'b0, 1'b0);
    accept_dly = 1;
    do_req(1'b0, 32'h100, 32'd0, 1'b0, 1'b1);

    // Write miss is memory-only; the following load misses.
    do_req(1'b1, 32'h400, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_req(1'b0, 32'h400, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, 32'h104, 32'd0, 1'b0, 1'b0);
    do_req(1'b1, 32'h104, 32'hA1B2_C3D4, 1'b1, 1'b0);

    // Reset while waiting for read data: late response must be ignored.
    resp_dly = 8;
    issue(1'b0, 32'h208, 32'd0);
    k = 0;
    while (n_mrd == 0 && k < 50) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("mid_rst_accept", 64'(n_mrd), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("mid_rst_cwe", 64'(cm_write_enable), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_hits = 0; exp_misses = 0;
    repeat (14) @(negedge clk);
    #2;
    check("mid_rst_no_resp", 64'(n_resp), 64'd0);
    check("mid_rst_no_fill", 64'(n_cwr), 64'd0);
    check("mid_rst_idle", 64'(req_ready), 64'd1);
    resp_dly = 2;

    // Victim pointers restart at 0 after reset.
    do_req(1'b0, 32'h500, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, 32'h208, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, 32'h208, 32'd0, 1'b1, 1'b0);

`ifdef CACHE_CTRL_PERF_EN
    check("hit_count", 64'(hit_count), 64'(exp_hits));
    check("miss_count", 64'(miss_count), 64'(exp_misses));
`endif
    check("sb_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for `cache_memory`: accepts single-word CPU load/store requests, performs the tag lookup, and handles read misses by fetching from main memory, choosing a victim way and filling the cache. Write policy is write-through, no-write-allocate. Sits between the core's data port and the main-memory bus. It is the only agent that drives `cache_memory` address and write ports.

## Interface
- `ADDR_SIZE`, 32, byte address width
- `NUM_SETS`, 4, sets in `cache_memory` (power of 2)
- `NUM_WAYS`, 2, ways per set (power of 2, ≥2)
- `BLOCK_SIZE`, 32, bits per block (one word)
- Derived:
  - `OffsetSize = $clog2(BLOCK_SIZE/8)`
  - `SetSize = $clog2(NUM_SETS)`
  - `WaySize = $clog2(NUM_WAYS)`
  - `TagSize = ADDR_SIZE - SetSize - OffsetSize`
  - set = `addr[OffsetSize +: SetSize]`; tag = upper `TagSize` bits
- Clock and reset: one clock; reset is asynchronous and active-low.

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in 1: CPU request
- `req_ready` out 1: controller can accept a request
- `req_write` in 1: 1 = store, 0 = load
- `req_addr` in ADDR_SIZE: request address
- `req_wdata` in 32: store data
- `resp_valid` out 1: one-cycle completion pulse
- `resp_rdata` out 32: load data; 0 for stores
- `cm_set` out SetSize: cache set index
- `cm_tag` out TagSize: cache tag
- `cm_write_way` out WaySize: cache write way
- `cm_write_enable` out 1: cache write strobe
- `cm_write_data` out 32: cache write data
- `cm_read_data` in 32: cache read data (combinational)
- `cm_hit` in 1: cache hit (combinational)
- `cm_hit_way` in WaySize: way that hit
- `cm_populate_way` in WaySize: first invalid way in the set
- `cm_populated` in 1: all ways of the set are valid
- `mem_req_valid` out 1: memory request
- `mem_req_ready` in 1: memory accepts the request
- `mem_req_write` out 1: memory write
- `mem_req_addr` out ADDR_SIZE: memory address
- `mem_req_wdata` out 32: memory write data
- `mem_resp_valid` in 1: read data return
- `mem_resp_rdata` in 32: memory read data

## Operation
- States: IDLE, LOOKUP, MEM_READ, WAIT_READ, FILL, MEM_WRITE.
- **IDLE:** `req_ready`=1. On `req_valid`, latch `req_write`, `req_addr` and `req_wdata`, then go to LOOKUP.
- `cm_set` and `cm_tag` are always driven from the latched address.
- **LOOKUP (read):**
  - Hit: register `cm_read_data` into `resp_rdata`, pulse `resp_valid` next cycle, go to IDLE.
  - Miss: go to MEM_READ.
- **LOOKUP (write):**
  - Hit: assert `cm_write_enable` with `cm_write_way`=`cm_hit_way` and `cm_write_data`=`req_wdata`.
  - Hit or miss: go to MEM_WRITE.
- **MEM_READ:** hold `mem_req_valid`=1, `mem_req_write`=0, `mem_req_addr`=latched address. On `mem_req_ready`, go to WAIT_READ.
- **WAIT_READ:** on `mem_resp_valid`, latch `mem_resp_rdata` and go to FILL.
- **FILL:**
  - Assert `cm_write_enable` with the memory data.
  - Way: `cm_populate_way` if `cm_populated`=0; otherwise `victim[set]`, then `victim[set]` increments and wraps from NUM_WAYS-1 to 0.
  - Pulse `resp_valid` with the data next cycle, go to IDLE.
- **MEM_WRITE:** hold the request with `mem_req_write`=1 and `mem_req_wdata`=`req_wdata`. On `mem_req_ready`, pulse `resp_valid` (`resp_rdata`=0) next cycle, go to IDLE.
- Request holding:
  - `mem_req_valid` stays asserted with stable fields until accepted.
  - `req_valid` outside IDLE is not accepted.
  - `mem_resp_valid` outside WAIT_READ is ignored.

## Timing
- Reset values:
  - state IDLE.
  - All outputs 0, including `req_ready` while `rst`=0.
  - All `victim` pointers 0.
- Reset mid-operation: any outstanding memory request is abandoned and no response is issued.
- Read-hit latency: request accepted at edge N, LOOKUP in cycle N+1, `resp_valid` in cycle N+2.
- Read-miss response: `resp_valid` one cycle after FILL.
- `cm_write_enable` is high for exactly one cycle per write or fill.
- `req_ready` returns high in the same cycle as `resp_valid`.

## Configuration
- `CACHE_CTRL_PERF_EN`
  - Defined: adds outputs `hit_count` and `miss_count`, each 32 bits, reset to 0.
  - They increment in LOOKUP on a hit or a miss respectively, for loads and stores, and saturate at 0xFFFF_FFFF.
  - Undefined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
Default parameters: set = `addr[3:2]`, tag = `addr[31:4]`.
- Reset: hold `rst`=0 for 2 cycles -> `req_ready`=0, `mem_req_valid`=0, `resp_valid`=0; after release, `req_ready`=1 on the next cycle.
- Read miss then hit: load 0x100, memory accepts after 2 cycles and returns 0xDEADBEEF 3 cycles later -> `mem_req_addr`=0x100, fill way 0, `resp_rdata`=0xDEADBEEF; repeat load -> `resp_valid` 2 cycles after acceptance, no `mem_req_valid`.
- Write hit: store 0x12345678 to 0x100 -> cache write to way 0 and memory write to 0x100; then load 0x100 -> 0x12345678 with no memory read.
- Replacement: loads to 0x100, 0x200, 0x300 (all set 0) -> fills to ways 0, 1, then way 0 (victim pointer 0 -> 1); load 0x100 -> miss.
- Write miss: store 0xCAFEF00D to 0x400 -> memory write only, `cm_write_enable` stays 0; load 0x400 -> miss.
- Reset during WAIT_READ: assert `rst`=0, then drive `mem_resp_valid` after release -> state IDLE, no `resp_valid`, no cache write.
